// File: rtl/ri_pkg.sv
// Shared types and encoding helpers for the R-type instruction encoder.
package ri_pkg;

  typedef enum logic [4:0] {
    RopAdd     = 5'd0,
    RopAddu    = 5'd1,
    RopSub     = 5'd2,
    RopSubu    = 5'd3,
    RopAnd     = 5'd4,
    RopOr      = 5'd5,
    RopXor     = 5'd6,
    RopNor     = 5'd7,
    RopSlt     = 5'd8,
    RopSltu    = 5'd9,
    RopMult    = 5'd10,
    RopMultu   = 5'd11,
    RopMfhi    = 5'd12,
    RopMflo    = 5'd13,
    RopSll     = 5'd14,
    RopSrl     = 5'd15,
    RopSra     = 5'd16,
    RopNop     = 5'd17,
    RopGpioOut = 5'd18,
    RopGpioIn  = 5'd19,
    RopMulLo   = 5'd20
  } rop_e;

  typedef enum logic {
    StIdle,
    StMacro2
  } state_e;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;

  function automatic logic [31:0] encode_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] shamt,
                                               input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, shamt, funct};
  endfunction

endpackage

// File: rtl/rtype_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data holds the last shown word while empty.
module rtype_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] w_head;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_rdata = o_empty ? r_last : w_head;

  // A full FIFO refuses a push even if the head leaves this same cycle.
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= o_rdata;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
        r_last   <= w_head;
      end
    end
  end

endmodule

// File: rtl/rtype_instr_encoder.sv
// Encodes R-type command tuples into MIPS words and streams them through a small FIFO.
module rtype_instr_encoder
  import ri_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [4:0]       i_cmd_op,
  input  logic [4:0]       i_cmd_rd,
  input  logic [4:0]       i_cmd_rs,
  input  logic [4:0]       i_cmd_rt,
  input  logic [4:0]       i_cmd_shamt,
  output logic             o_instr_valid,
  input  logic             i_instr_ready,
  output logic [31:0]      o_instr_data,
  output logic             o_cmd_err,
  output logic [CNT_W-1:0] o_word_count
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_alive;
  logic [4:0]       r_mac_rd;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_accept;
  logic        w_illegal;
  logic        w_macro;
  logic        w_err_nxt;
  logic [31:0] w_word;
  logic [31:0] w_wdata;

  always_comb begin
    w_word    = '0;
    w_illegal = 1'b0;
    w_macro   = 1'b0;
    case (i_cmd_op)
      RopAdd:   w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_ADD);
      RopAddu:  w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_ADDU);
      RopSub:   w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_SUB);
      RopSubu:  w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_SUBU);
      RopAnd:   w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_AND);
      RopOr:    w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_OR);
      RopXor:   w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_XOR);
      RopNor:   w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_NOR);
      RopSlt:   w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_SLT);
      RopSltu:  w_word = encode_rtype(i_cmd_rs, i_cmd_rt, i_cmd_rd, 5'd0, F_SLTU);
      RopMult:  w_word = encode_rtype(i_cmd_rs, i_cmd_rt, 5'd0, 5'd0, F_MULT);
      RopMultu: w_word = encode_rtype(i_cmd_rs, i_cmd_rt, 5'd0, 5'd0, F_MULTU);
      RopMfhi:  w_word = encode_rtype(5'd0, 5'd0, i_cmd_rd, 5'd0, F_MFHI);
      RopMflo:  w_word = encode_rtype(5'd0, 5'd0, i_cmd_rd, 5'd0, F_MFLO);
      RopSll: begin
        w_word    = encode_rtype(5'd0, i_cmd_rt, i_cmd_rd, i_cmd_shamt, F_SLL);
        w_illegal = (i_cmd_rd == 5'd0) && (i_cmd_shamt == 5'd0);
      end
      // Zero shift on SRL/SRA is reserved for the GPIO pseudo-ops.
      RopSrl: begin
        w_word    = encode_rtype(5'd0, i_cmd_rt, i_cmd_rd, i_cmd_shamt, F_SRL);
        w_illegal = (i_cmd_shamt == 5'd0);
      end
      RopSra: begin
        w_word    = encode_rtype(5'd0, i_cmd_rt, i_cmd_rd, i_cmd_shamt, F_SRA);
        w_illegal = (i_cmd_shamt == 5'd0);
      end
      RopNop:     w_word = '0;
      RopGpioOut: w_word = encode_rtype(5'd0, i_cmd_rt, 5'd0, 5'd0, F_SRL);
      RopGpioIn:  w_word = encode_rtype(5'd0, 5'd0, i_cmd_rd, 5'd0, F_SRA);
      RopMulLo: begin
        w_word  = encode_rtype(i_cmd_rs, i_cmd_rt, 5'd0, 5'd0, F_MULT);
        w_macro = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign o_cmd_ready = r_alive && (r_state == StIdle) && !w_full;
  assign w_accept    = i_cmd_valid && o_cmd_ready && !i_flush;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_wdata     = w_word;
    w_err_nxt   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_err_nxt = 1'b1;
          end else begin
            w_push = 1'b1;
            if (w_macro) begin
              w_state_nxt = StMacro2;
            end
          end
        end
      end
      StMacro2: begin
        w_wdata = encode_rtype(5'd0, 5'd0, r_mac_rd, 5'd0, F_MFLO);
        if (!w_full) begin
          w_push      = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (i_flush) begin
      w_state_nxt = StIdle;
      w_push      = 1'b0;
      w_err_nxt   = 1'b0;
    end
  end

  assign w_pop = i_instr_ready && !w_empty;

  rtype_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (o_instr_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_instr_valid = !w_empty;
  assign o_cmd_err     = r_err;
  assign o_word_count  = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_alive  <= 1'b0;
      r_mac_rd <= '0;
      r_err    <= 1'b0;
      r_count  <= '0;
    end else begin
      r_alive <= 1'b1;
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_accept && w_macro) begin
        r_mac_rd <= i_cmd_rd;
      end
      if (i_flush) begin
        r_count <= '0;
      end else if (w_push) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Directed and randomized bench for rtype_instr_encoder against a transaction-level word model.
module tb_rtype_instr_encoder;
  import ri_pkg::*;

  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            instr_ready = 1'b0;
  logic [4:0]      cmd_op = '0;
  logic [4:0]      cmd_rd = '0;
  logic [4:0]      cmd_rs = '0;
  logic [4:0]      cmd_rt = '0;
  logic [4:0]      cmd_shamt = '0;
  logic            cmd_ready;
  logic            instr_valid;
  logic            cmd_err;
  logic [31:0]     instr_data;
  logic [CntW-1:0] word_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          exp_count = 0;
  bit          exp_err = 1'b0;
  int          n_pops = 0;

  always #5 clk = ~clk;

  rtype_instr_encoder #(
    .FIFO_DEPTH(4),
    .CNT_W(CntW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_flush       (flush),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_rd      (cmd_rd),
    .i_cmd_rs      (cmd_rs),
    .i_cmd_rt      (cmd_rt),
    .i_cmd_shamt   (cmd_shamt),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_instr_data  (instr_data),
    .o_cmd_err     (cmd_err),
    .o_word_count  (word_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Word built arithmetically from field values.
  function automatic logic [31:0] fields(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input int f);
    return 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536 + 32'(rd) * 32'd2048
         + 32'(sh) * 32'd64 + 32'(f);
  endfunction

  function automatic int alu_funct(input int op);
    case (op)
      0: return 32;  1: return 33;  2: return 34;  3: return 35;  4: return 36;
      5: return 37;  6: return 38;  7: return 39;  8: return 42;  default: return 43;
    endcase
  endfunction

  // n = number of words produced; 0 means the command is illegal.
  function automatic void model_cmd(input int op, input logic [4:0] rd, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] sh,
                                    output int n, output logic [31:0] w0,
                                    output logic [31:0] w1);
    n  = 1;
    w0 = '0;
    w1 = '0;
    if (op <= 9) w0 = fields(rs, rt, rd, 5'd0, alu_funct(op));
    else begin
      case (op)
        10: w0 = fields(rs, rt, 5'd0, 5'd0, 24);
        11: w0 = fields(rs, rt, 5'd0, 5'd0, 25);
        12: w0 = fields(5'd0, 5'd0, rd, 5'd0, 16);
        13: w0 = fields(5'd0, 5'd0, rd, 5'd0, 18);
        14: if (rd == 0 && sh == 0) n = 0; else w0 = fields(5'd0, rt, rd, sh, 0);
        15: if (sh == 0) n = 0; else w0 = fields(5'd0, rt, rd, sh, 2);
        16: if (sh == 0) n = 0; else w0 = fields(5'd0, rt, rd, sh, 3);
        17: w0 = '0;
        18: w0 = fields(5'd0, rt, 5'd0, 5'd0, 2);
        19: w0 = fields(5'd0, 5'd0, rd, 5'd0, 3);
        20: begin
          n  = 2;
          w0 = fields(rs, rt, 5'd0, 5'd0, 24);
          w1 = fields(5'd0, 5'd0, rd, 5'd0, 18);
        end
        default: n = 0;
      endcase
    end
  endfunction

  // One clock: observe handshakes before the edge, update the model, check cmd_err after.
  task automatic step();
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          acc;
    bit          pop;
    acc = cmd_valid && cmd_ready && !flush;
    pop = instr_valid && instr_ready && !flush;
    if (pop) begin
      n_pops++;
      check_eq("word_in_model", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check_eq("word_order", instr_data, exp_q.pop_front());
    end
    exp_err = 1'b0;
    if (flush) begin
      exp_q.delete();
      exp_count = 0;
    end else if (acc) begin
      model_cmd(int'(cmd_op), cmd_rd, cmd_rs, cmd_rt, cmd_shamt, n, w0, w1);
      if (n == 0) exp_err = 1'b1;
      else begin
        exp_q.push_back(w0);
        if (n == 2) exp_q.push_back(w1);
        exp_count += n;
      end
    end
    @(posedge clk);
    #1;
    check_eq("cmd_err", {31'b0, cmd_err}, {31'b0, exp_err});
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] sh);
    bit done = 1'b0;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_shamt = sh;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      done = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    check_eq("send_accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, {31'b0, cmd_ready}, 32'd0);
    check_eq({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check_eq({tag, "_data"}, instr_data, 32'd0);
    check_eq({tag, "_err"}, {31'b0, cmd_err}, 32'd0);
    check_eq({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic fill_and_stall();
    do_flush();
    instr_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(RopAdd, 5'(i), 5'd1, 5'd2, 5'd0);
    send(RopMulLo, 5'd5, 5'd1, 5'd2, 5'd0);
    check_eq("t6_stall_ready", {31'b0, cmd_ready}, 32'd0);
    step();
    step();
    check_eq("t6_stall_count", 32'(word_count), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", {31'b0, cmd_ready}, 32'd1);

    // ADD and hold-last-value on empty
    instr_ready = 1'b1;
    send(RopAdd, 5'd3, 5'd1, 5'd2, 5'd0);
    check_eq("t1_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("t1_data", instr_data, 32'h0022_1820);
    check_eq("t1_count", 32'(word_count), 32'd1);
    step();
    check_eq("t1_empty", {31'b0, instr_valid}, 32'd0);
    check_eq("t1_hold", instr_data, 32'h0022_1820);

    // shifts: rs forced to zero, SRL shamt 0 illegal
    send(RopSll, 5'd4, 5'd9, 5'd2, 5'd5);
    check_eq("t2_sll", instr_data, 32'h0002_2140);
    step();
    send(RopSrl, 5'd4, 5'd0, 5'd2, 5'd0);
    check_eq("t2_srl_err", {31'b0, cmd_err}, 32'd1);
    check_eq("t2_srl_noword", {31'b0, instr_valid}, 32'd0);
    step();
    check_eq("t2_count", 32'(word_count), 32'd2);

    // MUL_LO macro
    do_flush();
    check_eq("t3_flush_count", 32'(word_count), 32'd0);
    send(RopMulLo, 5'd5, 5'd1, 5'd2, 5'd0);
    check_eq("t3_mult", instr_data, 32'h0022_0018);
    check_eq("t3_ready_low", {31'b0, cmd_ready}, 32'd0);
    step();
    check_eq("t3_mflo", instr_data, 32'h0000_2812);
    check_eq("t3_mflo_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("t3_ready_back", {31'b0, cmd_ready}, 32'd1);
    step();
    check_eq("t3_count", 32'(word_count), 32'd2);

    // pseudo-ops with junk in ignored fields
    send(RopGpioOut, 5'd3, 5'd4, 5'd7, 5'd6);
    check_eq("t4_gpio_out", instr_data, 32'h0007_0002);
    send(RopGpioIn, 5'd9, 5'd4, 5'd6, 5'd6);
    check_eq("t4_gpio_in", instr_data, 32'h0000_4803);
    send(RopNop, 5'd9, 5'd4, 5'd6, 5'd6);
    check_eq("t4_nop_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("t4_nop", instr_data, 32'h0000_0000);
    step();

    // backpressure: 4 fill the FIFO, 5th waits
    do_flush();
    instr_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(RopAdd, 5'(i), 5'd1, 5'd2, 5'd0);
    check_eq("t5_full_ready", {31'b0, cmd_ready}, 32'd0);
    check_eq("t5_count4", 32'(word_count), 32'd4);
    cmd_op    = RopAdd;
    cmd_rd    = 5'd5;
    cmd_valid = 1'b1;
    repeat (3) step();
    check_eq("t5_still_full", {31'b0, cmd_ready}, 32'd0);
    instr_ready = 1'b1;
    n_pops = 0;
    for (int i = 0; i < 30 && (cmd_valid || exp_q.size() != 0 || instr_valid); i++) begin
      bit take;
      take = cmd_ready;
      step();
      if (take) cmd_valid = 1'b0;
    end
    check_eq("t5_pops", 32'(n_pops), 32'd5);
    check_eq("t5_count5", 32'(word_count), 32'd5);

    // reset while MFLO is pending
    fill_and_stall();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    exp_count = 0;
    @(negedge clk);
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();
    check_eq("t6_rst_no_mflo", {31'b0, instr_valid}, 32'd0);
    check_eq("t6_rst_count", 32'(word_count), 32'd0);

    // flush while MFLO is pending
    fill_and_stall();
    do_flush();
    check_eq("t6_fl_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("t6_fl_count", 32'(word_count), 32'd0);
    check_eq("t6_fl_ready", {31'b0, cmd_ready}, 32'd1);
    instr_ready = 1'b1;
    repeat (3) step();
    check_eq("t6_fl_no_mflo", {31'b0, instr_valid}, 32'd0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      cmd_valid   = ($urandom_range(0, 9) < 7);
      cmd_op      = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(21, 31))
                                                : 5'($urandom_range(0, 20));
      cmd_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      cmd_shamt   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      cmd_rs      = 5'($urandom);
      cmd_rt      = 5'($urandom);
      instr_ready = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 63) == 0);
      step();
    end
    flush       = 1'b0;
    cmd_valid   = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || instr_valid); i++) step();
    check_eq("drain_model_empty", 32'(exp_q.size()), 32'd0);
    check_eq("drain_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("drain_count", 32'(word_count), 32'(exp_count % 65536));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
